// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   Asynchronous serial transmitter with a one-entry holding register.
//   Frame: start bit (0), p_data_bits data bits LSB first, optional parity bit,
//   one or two stop bits (1). Each bit lasts N = p_clk_speed_hz / p_baud_rate
//   clock cycles. Payload and frame format are latched at the handshake, so
//   configuration changes never affect a frame already accepted.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_n_i        synchronous active-low reset
//   tx_data_i      payload, LSB transmitted first
//   tx_valid_i     payload valid
//   tx_ready_o     holding register empty (handshake when valid & ready)
//   parity_mode_i  00 none, 01 even, 10 odd, 11 mark
//   stop_sel_i     0 one stop bit, 1 two stop bits
//   break_i        hold the line low while idle; start of a frame is deferred
//   tx_o           registered serial line, idle high
//   busy_o         frame in progress
//   frame_done_o   one-cycle pulse on the last cycle of each frame
module uart_tx_framer #(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600,
  parameter int p_data_bits    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [p_data_bits-1:0] tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [1:0]             parity_mode_i,
  input  logic                   stop_sel_i,
  input  logic                   break_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int unsigned N  = p_clk_speed_hz / p_baud_rate;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = $clog2(p_data_bits);

  localparam logic [CW-1:0] CNT_LAST    = CW'(N - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(N - 2);
  localparam logic [IW-1:0] BIT_LAST    = IW'(p_data_bits - 1);

  if (N < 2) begin : g_bad_rate
    $error("uart_tx_framer: bit period must be at least 2 clock cycles");
  end
  if (p_data_bits < 5 || p_data_bits > 9) begin : g_bad_width
    $error("uart_tx_framer: p_data_bits must be in 5..9");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          bit_idx;
  logic [p_data_bits-1:0] shreg;
  logic                   par_bit;
  logic                   par_en;
  logic                   stop_two;
  logic                   stop_second;

  logic                   hold_full;
  logic [p_data_bits-1:0] hold_data;
  logic [1:0]             hold_mode;
  logic                   hold_stop;

  logic                   tx_q;
  logic                   done_q;

  logic bit_end;
  logic pre_end;
  logic stop_last_period;
  logic handshake;
  logic start_frame;

  always_comb begin
    bit_end          = (cnt == CNT_LAST);
    pre_end          = (cnt == CNT_PRELAST);
    stop_last_period = stop_second || !stop_two;
    handshake        = tx_valid_i && !hold_full;
    // A frame starts from IDLE (unless break holds the line) or directly off
    // the last stop cycle of the previous frame, giving zero idle gap.
    start_frame      = hold_full &&
                       (((state == IDLE) && !break_i) ||
                        ((state == STOP) && bit_end && stop_last_period));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      par_en      <= 1'b0;
      stop_two    <= 1'b0;
      stop_second <= 1'b0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      hold_mode   <= '0;
      hold_stop   <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (handshake) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
        hold_mode <= parity_mode_i;
        hold_stop <= stop_sel_i;
      end

      case (state)
        IDLE: begin
          cnt  <= '0;
          tx_q <= ~break_i;
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_q    <= shreg[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              stop_second <= 1'b0;
              if (par_en) begin
                state <= PARITY;
                tx_q  <= par_bit;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt         <= '0;
            stop_second <= 1'b0;
            state       <= STOP;
            tx_q        <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // frame_done is registered, so it is armed one cycle before the end.
          if (pre_end && stop_last_period) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            cnt <= '0;
            if (!stop_last_period) begin
              stop_second <= 1'b1;
            end else begin
              state <= IDLE;
              tx_q  <= ~break_i;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase

      // Holding register moves into the shifter; overrides the case above.
      if (start_frame) begin
        state     <= START;
        cnt       <= '0;
        tx_q      <= 1'b0;
        hold_full <= 1'b0;
        shreg     <= hold_data;
        par_en    <= (hold_mode != 2'b00);
        stop_two  <= hold_stop;
        case (hold_mode)
          2'b10:   par_bit <= ~^hold_data;
          2'b11:   par_bit <= 1'b1;
          default: par_bit <= ^hold_data;
        endcase
      end
    end
  end

  assign tx_o         = tx_q;
  assign tx_ready_o   = ~hold_full;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = done_q;

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter p_clk_speed_hz, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter p_baud_rate, default 9_600, meaning line bit rate.
REQ-003 The block SHALL have parameter p_data_bits, default 8, legal 5..9, meaning data bits per frame.
REQ-004 The block SHALL have port clk_i, input, 1, system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1, reset, synchronous, active-low.
REQ-006 The block SHALL have port tx_data_i, input, p_data_bits, frame payload, LSB sent first.
REQ-007 The block SHALL have port tx_valid_i, input, 1, payload valid.
REQ-008 The block SHALL have port tx_ready_o, output, 1, holding register empty, payload acceptable.
REQ-009 The block SHALL have port parity_mode_i, input, 2, 00 none, 01 even, 10 odd, 11 mark (constant 1).
REQ-010 The block SHALL have port stop_sel_i, input, 1, 0 = one stop bit, 1 = two.
REQ-011 The block SHALL have port break_i, input, 1, request line break.
REQ-012 The block SHALL have port tx_o, output, 1, serial line, idle high.
REQ-013 The block SHALL have port busy_o, output, 1, frame in progress (state not IDLE).
REQ-014 The block SHALL have port frame_done_o, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-015 Bit period N SHALL be p_clk_speed_hz/p_baud_rate (integer division) clock cycles exactly; N<2 SHALL be an elaboration error.
REQ-016 The bit counter SHALL be $clog2(N) bits wide, count 0..N-1, and wrap to 0 at N-1.
REQ-017 A handshake SHALL occur on a cycle with tx_valid_i=1 and tx_ready_o=1; tx_data_i, parity_mode_i and stop_sel_i SHALL be captured into the holding register at that edge.
REQ-018 tx_ready_o SHALL be 0 while the holding register is full and SHALL NOT depend combinationally on tx_valid_i.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE->START SHALL occur on the edge after the holding register becomes full; the holding register moves to the shifter at that edge and tx_ready_o returns to 1 on the same edge.
REQ-021 START SHALL drive tx_o=0 for N cycles, then go to DATA.
REQ-022 DATA SHALL drive p_data_bits bits LSB first, N cycles each, then go to PARITY if the latched parity mode is not 00, else to STOP.
REQ-023 PARITY SHALL drive one bit for N cycles: even = XOR of data; odd = inverted XOR of data; mark = 1.
REQ-024 STOP SHALL drive tx_o=1 for N cycles, or 2N cycles if latched stop_sel=1.
REQ-025 frame_done_o SHALL pulse on the last cycle of STOP.
REQ-026 On that same last cycle, the FSM SHALL go to START if the holding register is full (back-to-back, zero idle gap), else to IDLE.
REQ-027 Configuration inputs SHALL be ignored mid-frame; each frame SHALL use the values latched at its own handshake.
REQ-028 break_i SHALL force tx_o=0 only in IDLE.
REQ-029 While break_i is 1 in IDLE, IDLE->START SHALL be inhibited, and the handshake SHALL still fill the holding register.
REQ-030 break_i SHALL be ignored mid-frame.
REQ-031 tx_o SHALL be registered, with no glitches.

Reset
REQ-032 When rst_n_i=0 at a rising edge, the block SHALL set tx_o=1, tx_ready_o=1, busy_o=0, frame_done_o=0, state IDLE, and clear the counters and holding register.
REQ-033 A reset during a frame SHALL abort the frame, return tx_o high on the next edge, and discard any pending held payload.

Verification
REQ-034 The bench SHALL cover: p_clk_speed_hz=50_000_000, p_baud_rate=5_000_000 (N=10), 8N1, data 0xA5 -> tx_o low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, high 10 cycles, then frame_done_o pulse; 100 cycles total.
REQ-035 The bench SHALL cover: parity 01 with 0x07 -> parity bit 1; parity 10 with 0x07 -> 0; parity 11 -> 1; stop_sel=1 -> stop high for 20 cycles.
REQ-036 The bench SHALL cover: p_data_bits=9 with data 0x1FF -> nine 1 bits; p_data_bits=5 -> frame of 70 cycles at 5N1.
REQ-037 The bench SHALL cover: a second handshake during frame 1 -> tx_ready_o low until frame 2 START, and frame 2 start bit on the cycle after frame 1's frame_done_o, with no idle cycle.
REQ-038 The bench SHALL cover: rst_n_i low in DATA bit 3 with a payload held -> tx_o=1 and tx_ready_o=1 after the edge, and no further frame.
REQ-039 The bench SHALL cover: break_i=1 in IDLE with a payload accepted -> tx_o=0 and no START; break_i deasserted -> START on the next edge.
